axis_capture: RTL and testbench
===============================

Name: axis_capture

Overview:
- AXI-Stream sink that records incoming beats into on-chip memory for post-run inspection.
- Counterpart of the stream-playback ROM: same data/keep/user/last layout, so captured contents can be compared beat-for-beat against playback contents.
- Sits at the output of a DUT datapath in test builds.
- Software or the bench arms it, then reads the memory back through a registered read port.

Parameters:
- AXIS_DATA_WIDTH, 512, tdata width in bits.
- AXIS_TUSER_WIDTH, 256, tuser width in bits.
- ADDR_WIDTH, 12, log2 of capture depth in beats (default depth 4096).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  AXIS_DATA_WIDTH  stream data.
- s_axis_tkeep  in  AXIS_DATA_WIDTH/8  byte enables.
- s_axis_tuser  in  AXIS_TUSER_WIDTH  sideband.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  end of packet.
- s_axis_tready  out  1  sink ready.
- arm  in  1  one-cycle pulse that starts or restarts a capture.
- max_pkts  in  16  number of packets to capture; 0 means capture until memory is full. Sampled on arm.
- rd_addr  in  ADDR_WIDTH  readback address.
- rd_tdata  out  AXIS_DATA_WIDTH  captured data at rd_addr.
- rd_tkeep  out  AXIS_DATA_WIDTH/8  captured keep at rd_addr.
- rd_tuser  out  AXIS_TUSER_WIDTH  captured user at rd_addr.
- rd_tlast  out  1  captured last at rd_addr.
- beat_count  out  ADDR_WIDTH+1  beats stored.
- pkt_count  out  16  complete packets stored.
- busy  out  1  capture in progress (WAIT_SOP or CAPTURE).
- done  out  1  capture finished (level).
- overflow  out  1  memory filled mid-packet.

Behaviour:
- Reset values (async, rst=1):
  - State = IDLE.
  - s_axis_tready = 0, then registered to 1 on the first clock after reset release; stays 1 thereafter.
  - beat_count, pkt_count, busy, done, overflow, in_pkt = 0.
  - rd_* outputs = 0.
  - Memory contents are not reset.
- Backpressure: never asserted. Beats arriving in IDLE or DONE are accepted and discarded.
- Beat definition: a beat is tvalid && tready.
- in_pkt flag:
  - Updates on every beat in every state.
  - Set on a beat with tlast=0; cleared on a beat with tlast=1.
  - Used to find a packet boundary.
- States:
  - IDLE: waits for arm.
  - WAIT_SOP: discards beats while in_pkt=1. The first beat seen with in_pkt=0 is written to address 0, and the state moves to CAPTURE, with tlast handling applied to that same beat.
  - CAPTURE: each beat writes {tdata, tkeep, tuser, tlast} to address beat_count[ADDR_WIDTH-1:0], then beat_count increments.
  - DONE: holds all counts; done=1.
- arm, from any state:
  - Next cycle: beat_count=0, pkt_count=0, overflow=0, done=0; max_pkts latched; state = WAIT_SOP.
  - A beat coincident with the arm cycle is not stored, but does update in_pkt.
- tlast beat while capturing:
  - pkt_count increments.
  - If the latched max_pkts != 0 and the new pkt_count equals max_pkts, go to DONE.
- Full condition, on the beat written to address 2^ADDR_WIDTH-1 (beat_count becomes 2^ADDR_WIDTH):
  - Always go to DONE.
  - If that beat has tlast=0, set overflow=1.
  - If it has tlast=1, count the packet normally; overflow stays 0.
- Simultaneous max_pkts hit and full on the same beat: DONE, overflow=0.
- busy=1 exactly in WAIT_SOP and CAPTURE; done=1 exactly in DONE.
- Readback:
  - rd_* are registered from memory at rd_addr, 1-cycle latency, usable in any state.
  - A read and a write to the same address in the same cycle return the old contents (read-first).
- Memory maps to block RAM: one write port (capture), one read port (readback).

Test Plan:
- Reset, then arm with max_pkts=2. Send 3 packets of 3, 1 and 2 beats (tdata = beat index). Required response:
  - done=1 one cycle after the last beat of packet 2; pkt_count=2; beat_count=4; overflow=0.
  - Reading addr 0..3 returns tdata 0,1,2,3 and tlast 0,0,1,1.
  - Packet 3 is not stored.
- Arm while a 4-beat packet is on beat 2, then send a 2-beat packet. Required response: the partial packet is discarded; addr 0 holds the first beat of the 2-beat packet; beat_count=2.
- ADDR_WIDTH=4, max_pkts=0, one 20-beat packet. Required response: done after 16 beats; beat_count=16; overflow=1; pkt_count=0.
- ADDR_WIDTH=4, max_pkts=0, two 8-beat packets. Required response: done; beat_count=16; pkt_count=2; overflow=0.
- Assert rst mid-capture (after 5 beats), release, then read addr 0..4. Required response:
  - All counts and flags are 0; state is IDLE; s_axis_tready is 1 after release.
  - Previously written memory words still read back intact.
- tvalid toggling every cycle with random tkeep/tuser, max_pkts=1, 6-beat packet. Required response: all 6 beats stored with exact tkeep/tuser; no beats are lost during tvalid gaps.

Source files
------------

// File: rtl/axis_capture.sv
// axis_capture
//   AXI-Stream sink that records incoming beats into a simple dual-port
//   memory for later inspection. Each stored word is {tlast, tuser, tkeep, tdata},
//   which is the same layout the stream-playback ROM uses.
//
// Ports
//   clk, rst           single clock, asynchronous active-high reset
//   s_axis_*           stream input; tready is never deasserted after reset
//   arm, max_pkts      start/restart a capture; max_pkts=0 captures until full
//   rd_addr, rd_*      registered readback port, 1-cycle latency, read-first
//   beat_count         beats stored
//   pkt_count          complete packets stored
//   busy, done         capture in progress / capture finished
//   overflow           memory filled in the middle of a packet
module axis_capture #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int ADDR_WIDTH       = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  input  logic                          arm,
  input  logic [15:0]                   max_pkts,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [AXIS_DATA_WIDTH-1:0]    rd_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  rd_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   rd_tuser,
  output logic                          rd_tlast,
  output logic [ADDR_WIDTH:0]           beat_count,
  output logic [15:0]                   pkt_count,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  // state    | meaning
  // S_IDLE   | waiting for arm, beats discarded
  // S_WAIT   | armed, discarding the tail of a packet already in flight
  // S_CAPT   | storing every beat
  // S_DONE   | packet limit reached or memory full, counts held
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_DONE} state_t;

  localparam int KW    = AXIS_DATA_WIDTH / 8;
  localparam int MW    = AXIS_DATA_WIDTH + KW + AXIS_TUSER_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t state, state_nxt;

  logic          in_pkt;
  logic [15:0]   max_lat;
  logic          beat;
  logic          cap;
  logic          full;
  logic          max_hit;
  logic [15:0]   pkt_inc;

  logic [MW-1:0] mem [0:DEPTH-1];
  logic [MW-1:0] rd_word;

  assign beat    = s_axis_tvalid && s_axis_tready;
  // A beat coincident with arm is never stored; in WAIT the first beat that
  // starts a fresh packet (in_pkt still clear) is the first one kept.
  assign cap     = beat && !arm &&
                   ((state == S_CAPT) || ((state == S_WAIT) && !in_pkt));
  assign full    = (beat_count == LAST_ADDR);
  assign pkt_inc = pkt_count + 16'd1;
  assign max_hit = s_axis_tlast && (max_lat != 16'd0) && (pkt_inc == max_lat);

  assign busy = (state == S_WAIT) || (state == S_CAPT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = S_WAIT;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_IDLE;
        S_WAIT, S_CAPT: begin
          if (cap) begin
            state_nxt = (max_hit || full) ? S_DONE : S_CAPT;
          end
        end
        S_DONE: state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axis_tready <= 1'b0;
      in_pkt        <= 1'b0;
      beat_count    <= '0;
      pkt_count     <= '0;
      overflow      <= 1'b0;
      max_lat       <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      if (beat) begin
        in_pkt <= !s_axis_tlast;
      end
      if (arm) begin
        beat_count <= '0;
        pkt_count  <= '0;
        overflow   <= 1'b0;
        max_lat    <= max_pkts;
      end else if (cap) begin
        beat_count <= beat_count + 1'b1;
        if (s_axis_tlast) begin
          pkt_count <= pkt_inc;
        end
        // A packet that ends exactly on the last word is counted, not an overflow.
        if (full && !s_axis_tlast) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Capture memory: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (cap) begin
      mem[beat_count[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
    end
  end

  // Separate non-blocking read gives read-first behaviour on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_word <= '0;
    end else begin
      rd_word <= mem[rd_addr];
    end
  end

  assign rd_tdata = rd_word[AXIS_DATA_WIDTH-1:0];
  assign rd_tkeep = rd_word[AXIS_DATA_WIDTH +: KW];
  assign rd_tuser = rd_word[AXIS_DATA_WIDTH+KW +: AXIS_TUSER_WIDTH];
  assign rd_tlast = rd_word[MW-1];

endmodule

// File: tb/tb_axis_capture.sv
module tb_axis_capture;

  localparam int DW = 64;
  localparam int UW = 32;
  localparam int AW = 4;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '1;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          arm = 1'b0;
  logic [15:0]   max_pkts = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_tdata;
  logic [KW-1:0] rd_tkeep;
  logic [UW-1:0] rd_tuser;
  logic          rd_tlast;
  logic [AW:0]   beat_count;
  logic [15:0]   pkt_count;
  logic          busy;
  logic          done;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_capture #(
    .AXIS_DATA_WIDTH (DW),
    .AXIS_TUSER_WIDTH(UW),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .arm          (arm),
    .max_pkts     (max_pkts),
    .rd_addr      (rd_addr),
    .rd_tdata     (rd_tdata),
    .rd_tkeep     (rd_tkeep),
    .rd_tuser     (rd_tuser),
    .rd_tlast     (rd_tlast),
    .beat_count   (beat_count),
    .pkt_count    (pkt_count),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  task automatic beat(input logic [DW-1:0] d, input logic l, input logic a);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    arm           = a;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    arm           = 1'b0;
  endtask

  task automatic do_arm(input logic [15:0] m);
    max_pkts = m;
    arm      = 1'b1;
    @(posedge clk); #1;
    arm      = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_addr = a;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %0b want 0", s_axis_tready); end
    checks++; if (beat_count !== 5'd0) begin errors++; $display("FAIL rst_beat_count: got %0d want 0", beat_count); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
    checks++; if ({busy, done, overflow} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {busy, done, overflow}); end
    checks++; if (rd_tdata !== '0 || rd_tlast !== 1'b0) begin errors++; $display("FAIL rst_rd: got %0h/%0b want 0/0", rd_tdata, rd_tlast); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rel_tready_early: got %0b want 0", s_axis_tready); end
    @(posedge clk); #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rel_tready: got %0b want 1", s_axis_tready); end
    beat(64'h77, 1'b1, 1'b0);
    checks++; if (beat_count !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_discard: got bc=%0d busy=%0b want 0/0", beat_count, busy); end
  endtask

  task automatic test_max_pkts;
    do_arm(16'd2);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mp_armed: got busy=%0b done=%0b want 1/0", busy, done); end
    beat(64'd0, 1'b0, 1'b0);
    beat(64'd1, 1'b0, 1'b0);
    beat(64'd2, 1'b1, 1'b0);
    checks++; if (done !== 1'b0 || pkt_count !== 16'd1) begin errors++; $display("FAIL mp_mid: got done=%0b pkts=%0d want 0/1", done, pkt_count); end
    beat(64'd3, 1'b1, 1'b0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mp_done: got done=%0b busy=%0b want 1/0", done, busy); end
    checks++; if (pkt_count !== 16'd2 || beat_count !== 5'd4 || overflow !== 1'b0) begin errors++; $display("FAIL mp_counts: got pkts=%0d beats=%0d ovf=%0b want 2/4/0", pkt_count, beat_count, overflow); end
    beat(64'd4, 1'b0, 1'b0);
    beat(64'd5, 1'b1, 1'b0);
    checks++; if (beat_count !== 5'd4 || pkt_count !== 16'd2) begin errors++; $display("FAIL mp_pkt3_ignored: got beats=%0d pkts=%0d want 4/2", beat_count, pkt_count); end
    for (int i = 0; i < 4; i++) begin
      rd(i[AW-1:0]);
      checks++; if (rd_tdata !== DW'(i)) begin errors++; $display("FAIL mp_rd_data[%0d]: got %0h want %0h", i, rd_tdata, i); end
      checks++; if (rd_tlast !== (i >= 2)) begin errors++; $display("FAIL mp_rd_last[%0d]: got %0b want %0b", i, rd_tlast, (i >= 2)); end
    end
  endtask

  task automatic test_arm_mid_packet;
    max_pkts = 16'd0;
    beat(64'h10, 1'b0, 1'b0);
    beat(64'h11, 1'b0, 1'b1);
    beat(64'h12, 1'b0, 1'b0);
    beat(64'h13, 1'b1, 1'b0);
    checks++; if (beat_count !== 5'd0 || busy !== 1'b1) begin errors++; $display("FAIL am_discard: got beats=%0d busy=%0b want 0/1", beat_count, busy); end
    beat(64'h20, 1'b0, 1'b0);
    beat(64'h21, 1'b1, 1'b0);
    checks++; if (beat_count !== 5'd2 || pkt_count !== 16'd1) begin errors++; $display("FAIL am_counts: got beats=%0d pkts=%0d want 2/1", beat_count, pkt_count); end
    rd(4'd0);
    checks++; if (rd_tdata !== 64'h20 || rd_tlast !== 1'b0) begin errors++; $display("FAIL am_rd0: got %0h/%0b want 20/0", rd_tdata, rd_tlast); end
    rd(4'd1);
    checks++; if (rd_tdata !== 64'h21 || rd_tlast !== 1'b1) begin errors++; $display("FAIL am_rd1: got %0h/%0b want 21/1", rd_tdata, rd_tlast); end
  endtask

  task automatic test_overflow;
    do_arm(16'd0);
    for (int i = 0; i < 16; i++) beat(DW'(100 + i), 1'b0, 1'b0);
    checks++; if (done !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_flags: got done=%0b ovf=%0b want 1/1", done, overflow); end
    checks++; if (beat_count !== 5'd16 || pkt_count !== 16'd0) begin errors++; $display("FAIL ovf_counts: got beats=%0d pkts=%0d want 16/0", beat_count, pkt_count); end
    for (int i = 16; i < 20; i++) beat(DW'(100 + i), (i == 19), 1'b0);
    checks++; if (beat_count !== 5'd16 || pkt_count !== 16'd0 || done !== 1'b1) begin errors++; $display("FAIL ovf_hold: got beats=%0d pkts=%0d done=%0b want 16/0/1", beat_count, pkt_count, done); end
    rd(4'd15);
    checks++; if (rd_tdata !== DW'(115) || rd_tlast !== 1'b0) begin errors++; $display("FAIL ovf_rd15: got %0d/%0b want 115/0", rd_tdata, rd_tlast); end
  endtask

  task automatic test_full_exact;
    do_arm(16'd0);
    for (int i = 0; i < 16; i++) beat(DW'(200 + i), (i % 8 == 7), 1'b0);
    checks++; if (done !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL full_flags: got done=%0b ovf=%0b want 1/0", done, overflow); end
    checks++; if (beat_count !== 5'd16 || pkt_count !== 16'd2) begin errors++; $display("FAIL full_counts: got beats=%0d pkts=%0d want 16/2", beat_count, pkt_count); end
    rd(4'd7);
    checks++; if (rd_tdata !== DW'(207) || rd_tlast !== 1'b1) begin errors++; $display("FAIL full_rd7: got %0d/%0b want 207/1", rd_tdata, rd_tlast); end
    // Packet limit and memory full land on the same beat.
    do_arm(16'd2);
    for (int i = 0; i < 16; i++) beat(DW'(200 + i), (i % 8 == 7), 1'b0);
    checks++; if (done !== 1'b1 || overflow !== 1'b0 || pkt_count !== 16'd2) begin errors++; $display("FAIL both_hit: got done=%0b ovf=%0b pkts=%0d want 1/0/2", done, overflow, pkt_count); end
  endtask

  task automatic test_reset_mid;
    do_arm(16'd0);
    for (int i = 0; i < 5; i++) beat(DW'(300 + i), 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    checks++; if (beat_count !== 5'd0 || pkt_count !== 16'd0 || {busy, done, overflow} !== 3'b000) begin errors++; $display("FAIL rm_clear: got beats=%0d pkts=%0d flags=%b want 0/0/000", beat_count, pkt_count, {busy, done, overflow}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_axis_tready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_release: got tready=%0b busy=%0b done=%0b want 1/0/0", s_axis_tready, busy, done); end
    for (int i = 0; i < 5; i++) begin
      rd(i[AW-1:0]);
      checks++; if (rd_tdata !== DW'(300 + i)) begin errors++; $display("FAIL rm_mem[%0d]: got %0d want %0d", i, rd_tdata, 300 + i); end
    end
  endtask

  task automatic test_back_to_back_gaps;
    logic [KW-1:0] exp_keep [6];
    logic [UW-1:0] exp_user [6];
    do_arm(16'd1);
    for (int i = 0; i < 6; i++) begin
      exp_keep[i] = KW'($urandom_range(0, 255));
      exp_user[i] = $urandom;
      s_axis_tkeep = exp_keep[i];
      s_axis_tuser = exp_user[i];
      beat(DW'(400 + i), (i == 5), 1'b0);
      s_axis_tdata = 64'hDEAD;
      s_axis_tkeep = '0;
      s_axis_tuser = '1;
      @(posedge clk); #1;
    end
    checks++; if (done !== 1'b1 || beat_count !== 5'd6 || pkt_count !== 16'd1) begin errors++; $display("FAIL gap_counts: got done=%0b beats=%0d pkts=%0d want 1/6/1", done, beat_count, pkt_count); end
    for (int i = 0; i < 6; i++) begin
      rd(i[AW-1:0]);
      checks++; if (rd_tdata !== DW'(400 + i) || rd_tkeep !== exp_keep[i] || rd_tuser !== exp_user[i] || rd_tlast !== (i == 5)) begin
        errors++; $display("FAIL gap_rd[%0d]: got %0d/%0h/%0h/%0b want %0d/%0h/%0h/%0b", i, rd_tdata, rd_tkeep, rd_tuser, rd_tlast, 400 + i, exp_keep[i], exp_user[i], (i == 5));
      end
    end
  endtask

  task automatic test_read_first;
    do_arm(16'd0);
    s_axis_tkeep = '1;
    rd_addr = 4'd0;
    beat(64'd500, 1'b0, 1'b0);
    checks++; if (rd_tdata !== 64'd400) begin errors++; $display("FAIL rf_old: got %0d want 400", rd_tdata); end
    rd(4'd0);
    checks++; if (rd_tdata !== 64'd500 || beat_count !== 5'd1) begin errors++; $display("FAIL rf_new: got %0d beats=%0d want 500/1", rd_tdata, beat_count); end
  endtask

  initial begin
    test_reset;
    test_max_pkts;
    test_arm_mid_packet;
    test_overflow;
    test_full_exact;
    test_reset_mid;
    test_back_to_back_gaps;
    test_read_first;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
